i2c_slave_reg_ctrl: RTL and testbench



---
 rtl/i2c_slave_reg_ctrl_if.sv | 42 ++++
 rtl/i2c_slave_reg_ctrl.sv | 115 +++++++++++
 tb/tb_i2c_slave_reg_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_reg_ctrl_if.sv
// Bundle of I2C slave handshake, host register port and status signals.
// The controller uses the slave modport; its environment uses the master modport.
interface i2c_slave_reg_ctrl_if #(
    parameter int PTR_W = 4
);
    logic             en;
    logic             i2c_rd_full;
    logic [7:0]       i2c_rd_data;
    logic             i2c_rd_clr;
    logic             i2c_wr_rdy;
    logic [7:0]       i2c_wr_data;
    logic             i2c_addr_match;
    logic             i2c_trans_dir;
    logic             i2c_byte_wait;
    logic             i2c_trans_stop;
    logic             i2c_bus_err;
    logic [PTR_W-1:0] host_addr;
    logic             host_we;
    logic [7:0]       host_wdata;
    logic [7:0]       host_rdata;
    logic             reg_wr_strobe;
    logic [PTR_W-1:0] reg_wr_addr;
    logic [7:0]       reg_wr_data;
    logic [PTR_W-1:0] ptr_o;
    logic             busy;

    modport slave (
        input  en, i2c_rd_full, i2c_rd_data, i2c_addr_match, i2c_trans_dir,
               i2c_byte_wait, i2c_trans_stop, i2c_bus_err,
               host_addr, host_we, host_wdata,
        output i2c_rd_clr, i2c_wr_rdy, i2c_wr_data, host_rdata,
               reg_wr_strobe, reg_wr_addr, reg_wr_data, ptr_o, busy
    );

    modport master (
        output en, i2c_rd_full, i2c_rd_data, i2c_addr_match, i2c_trans_dir,
               i2c_byte_wait, i2c_trans_stop, i2c_bus_err,
               host_addr, host_we, host_wdata,
        input  i2c_rd_clr, i2c_wr_rdy, i2c_wr_data, host_rdata,
               reg_wr_strobe, reg_wr_addr, reg_wr_data, ptr_o, busy
    );
endinterface

// File: rtl/i2c_slave_reg_ctrl.sv
// Byte sequencer between an I2C slave and a local register bank: pointer byte,
// auto-incrementing writes/reads, and a host port into the same bank.
module i2c_slave_reg_ctrl #(
    parameter int         PTR_W   = 4,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input logic clk,
    input logic rst,
    i2c_slave_reg_ctrl_if.slave bus
);
    localparam int REG_NUM = 2 ** PTR_W;

    typedef enum logic [1:0] {IDLE, PTR, WDATA, RDATA} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [1:0]       holdoff_q, holdoff_d;
    logic             addrMatch_q;
    logic [7:0]       regs_q [REG_NUM];
    logic             rdClr_q, wrRdy_q, strobe_q, busy_q;
    logic [7:0]       wrData_q, hostRdata_q, strobeData_q;
    logic [PTR_W-1:0] strobeAddr_q;

    logic addrDone, abort, byteOk, rdAccept, wrAccept, i2cWe, hostWe;

    // Priority: disable > bus error > stop > address done > byte handling.
    always_comb begin
        addrDone = addrMatch_q & ~bus.i2c_addr_match;
        abort    = ~bus.en | bus.i2c_bus_err | bus.i2c_trans_stop;
        byteOk   = ~abort & ~addrDone & (holdoff_q == 2'd0);
        rdAccept = byteOk & bus.i2c_rd_full;
        wrAccept = byteOk & (state_q == RDATA) & bus.i2c_byte_wait & bus.i2c_trans_dir;
        i2cWe    = rdAccept & (state_q == WDATA);
        hostWe   = bus.host_we & ~(i2cWe & (bus.host_addr == ptr_q));

        state_d = state_q;
        ptr_d   = ptr_q;
        if (abort) begin
            state_d = IDLE;
        end else if (addrDone) begin
            state_d = bus.i2c_trans_dir ? RDATA : PTR;
        end else if (rdAccept && state_q == PTR) begin
            state_d = WDATA;
            ptr_d   = bus.i2c_rd_data[PTR_W-1:0];
        end else if (i2cWe || wrAccept) begin
            ptr_d = ptr_q + 1'b1;
        end

        if (rdAccept || wrAccept) begin
            holdoff_d = 2'd2;
        end else if (holdoff_q != 2'd0) begin
            holdoff_d = holdoff_q - 2'd1;
        end else begin
            holdoff_d = 2'd0;
        end
    end

    // Host read data forwards a same-cycle write so it never shows a stale byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            holdoff_q    <= 2'd0;
            addrMatch_q  <= 1'b0;
            busy_q       <= 1'b0;
            rdClr_q      <= 1'b0;
            wrRdy_q      <= 1'b0;
            wrData_q     <= 8'h00;
            strobe_q     <= 1'b0;
            strobeAddr_q <= '0;
            strobeData_q <= 8'h00;
            hostRdata_q  <= 8'h00;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            holdoff_q   <= holdoff_d;
            addrMatch_q <= bus.i2c_addr_match;
            busy_q      <= (state_d != IDLE);
            rdClr_q     <= rdAccept;
            wrRdy_q     <= wrAccept;
            strobe_q    <= i2cWe;
            if (wrAccept) begin
                wrData_q <= regs_q[ptr_q];
            end
            if (i2cWe) begin
                regs_q[ptr_q] <= bus.i2c_rd_data;
                strobeAddr_q  <= ptr_q;
                strobeData_q  <= bus.i2c_rd_data;
            end
            if (hostWe) begin
                regs_q[bus.host_addr] <= bus.host_wdata;
            end
            if (i2cWe && bus.host_addr == ptr_q) begin
                hostRdata_q <= bus.i2c_rd_data;
            end else if (bus.host_we) begin
                hostRdata_q <= bus.host_wdata;
            end else begin
                hostRdata_q <= regs_q[bus.host_addr];
            end
        end
    end

    assign bus.i2c_rd_clr    = rdClr_q;
    assign bus.i2c_wr_rdy    = wrRdy_q;
    assign bus.i2c_wr_data   = wrData_q;
    assign bus.host_rdata    = hostRdata_q;
    assign bus.reg_wr_strobe = strobe_q;
    assign bus.reg_wr_addr   = strobeAddr_q;
    assign bus.reg_wr_data   = strobeData_q;
    assign bus.ptr_o         = ptr_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Directed bench for i2c_slave_reg_ctrl: stimulus pushes expected bytes into
// queues, a negedge monitor pops them whenever the DUT pulses wr_rdy or a strobe.
module tb_i2c_slave_reg_ctrl;
    localparam int PTR_W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   rdClrCount;

    logic [7:0]         expWr[$];
    logic [PTR_W+7:0]   expStrobe[$];

    i2c_slave_reg_ctrl_if #(.PTR_W(PTR_W)) bus ();

    i2c_slave_reg_ctrl #(.PTR_W(PTR_W), .RST_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every output pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.i2c_rd_clr) rdClrCount++;
            if (bus.i2c_wr_rdy) begin
                if (expWr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL wrRdyUnexpected actual=%0h required=none", bus.i2c_wr_data);
                end else begin
                    checkOutput("wrData", {24'h0, bus.i2c_wr_data}, {24'h0, expWr.pop_front()});
                end
            end
            if (bus.reg_wr_strobe) begin
                if (expStrobe.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL strobeUnexpected actual=%0h/%0h required=none",
                             bus.reg_wr_addr, bus.reg_wr_data);
                end else begin
                    checkOutput("strobeAddrData", {20'h0, bus.reg_wr_addr, bus.reg_wr_data},
                                {20'h0, expStrobe.pop_front()});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one received byte, optionally with a host write in the accept cycle.
    task automatic applyStimulus(input logic [7:0] data, input logic hostWe,
                                 input logic [PTR_W-1:0] hostAddr, input logic [7:0] hostWdata);
        logic seen;
        seen = 1'b0;
        bus.i2c_rd_full = 1'b1;
        bus.i2c_rd_data = data;
        bus.host_we     = hostWe;
        bus.host_addr   = hostAddr;
        bus.host_wdata  = hostWdata;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1;
            bus.host_we = 1'b0;
            if (bus.i2c_rd_clr) seen = 1'b1;
        end
        bus.i2c_rd_full = 1'b0;
        checkOutput("rdClrSeen", {31'h0, seen}, 32'h1);
    endtask

    task automatic sendByte(input logic [7:0] data);
        applyStimulus(data, 1'b0, bus.host_addr, 8'h00);
        tick(3);
    endtask

    task automatic addrDone(input logic dir);
        bus.i2c_trans_dir  = dir;
        bus.i2c_addr_match = 1'b1;
        tick(1);
        bus.i2c_addr_match = 1'b0;
        tick(2);
    endtask

    task automatic hostWrite(input logic [PTR_W-1:0] addr, input logic [7:0] data);
        bus.host_addr  = addr;
        bus.host_wdata = data;
        bus.host_we    = 1'b1;
        tick(1);
        bus.host_we = 1'b0;
        checkOutput("hostFwd", {24'h0, bus.host_rdata}, {24'h0, data});
    endtask

    task automatic hostRead(input string name, input logic [PTR_W-1:0] addr, input logic [7:0] exp);
        bus.host_addr = addr;
        tick(2);
        checkOutput(name, {24'h0, bus.host_rdata}, {24'h0, exp});
    endtask

    initial begin
        int base;
        int pulses;
        checks     = 0;
        errors     = 0;
        rdClrCount = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.i2c_rd_full = 1'b0;
        bus.i2c_rd_data = 8'h00;
        bus.i2c_addr_match = 1'b0;
        bus.i2c_trans_dir = 1'b0;
        bus.i2c_byte_wait = 1'b0;
        bus.i2c_trans_stop = 1'b0;
        bus.i2c_bus_err = 1'b0;
        bus.host_addr = '0;
        bus.host_we = 1'b0;
        bus.host_wdata = 8'h00;
        tick(3);
        checkOutput("rstPtr", {28'h0, bus.ptr_o}, 32'h0);
        checkOutput("rstBusy", {31'h0, bus.busy}, 32'h0);
        checkOutput("rstRdClr", {31'h0, bus.i2c_rd_clr}, 32'h0);
        checkOutput("rstWrRdy", {31'h0, bus.i2c_wr_rdy}, 32'h0);
        checkOutput("rstHostRdata", {24'h0, bus.host_rdata}, 32'h0);
        rst = 1'b0;
        bus.en = 1'b1;
        tick(2);

        hostWrite(4'd15, 8'hC3);
        hostWrite(4'd0, 8'h81);
        hostWrite(4'd1, 8'h7E);

        // Write transaction: pointer 3, then two data bytes.
        base = rdClrCount;
        addrDone(1'b0);
        checkOutput("busyPtr", {31'h0, bus.busy}, 32'h1);
        sendByte(8'h03);
        expStrobe.push_back({4'd3, 8'hA5});
        sendByte(8'hA5);
        expStrobe.push_back({4'd4, 8'h5A});
        sendByte(8'h5A);
        checkOutput("ptrAfterWrite", {28'h0, bus.ptr_o}, 32'h5);
        checkOutput("rdClrCount3", rdClrCount - base, 32'd3);
        hostRead("reg3", 4'd3, 8'hA5);
        hostRead("reg4", 4'd4, 8'h5A);

        // Pointer 15, repeated start into a read of three bytes with wrap.
        addrDone(1'b0);
        sendByte(8'h0F);
        addrDone(1'b1);
        checkOutput("busyRead", {31'h0, bus.busy}, 32'h1);
        expWr.push_back(8'hC3);
        expWr.push_back(8'h81);
        expWr.push_back(8'h7E);
        pulses = 0;
        bus.i2c_byte_wait = 1'b1;
        for (int c = 0; c < 30 && pulses < 3; c++) begin
            tick(1);
            if (bus.i2c_wr_rdy) pulses++;
        end
        tick(2);
        bus.i2c_byte_wait = 1'b0;
        tick(3);
        checkOutput("wrLoads", pulses, 32'd3);
        checkOutput("ptrWrap", {28'h0, bus.ptr_o}, 32'h2);
        bus.i2c_trans_stop = 1'b1;
        tick(1);
        bus.i2c_trans_stop = 1'b0;
        bus.i2c_trans_dir  = 1'b0;
        checkOutput("busyStop", {31'h0, bus.busy}, 32'h0);

        // Same-index collision, then a different-index host write alongside.
        addrDone(1'b0);
        sendByte(8'h07);
        expStrobe.push_back({4'd7, 8'h11});
        applyStimulus(8'h11, 1'b1, 4'd7, 8'h22);
        checkOutput("collisionFwd", {24'h0, bus.host_rdata}, 32'h11);
        tick(3);
        expStrobe.push_back({4'd8, 8'h33});
        applyStimulus(8'h33, 1'b1, 4'd2, 8'h44);
        tick(3);
        hostRead("reg7", 4'd7, 8'h11);
        hostRead("reg8", 4'd8, 8'h33);
        hostRead("reg2", 4'd2, 8'h44);

        // Pointer byte upper bits ignored.
        addrDone(1'b0);
        sendByte(8'hF2);
        checkOutput("ptrF2", {28'h0, bus.ptr_o}, 32'h2);
        bus.i2c_trans_stop = 1'b1;
        tick(1);
        bus.i2c_trans_stop = 1'b0;

        // Stray byte in IDLE is drained without touching registers.
        base = rdClrCount;
        sendByte(8'h77);
        checkOutput("strayRdClr", rdClrCount - base, 32'd1);
        checkOutput("strayPtr", {28'h0, bus.ptr_o}, 32'h2);
        hostRead("strayReg2", 4'd2, 8'h44);

        // Bus error in WDATA returns to IDLE with pointer kept.
        addrDone(1'b0);
        sendByte(8'h05);
        bus.i2c_bus_err = 1'b1;
        tick(1);
        bus.i2c_bus_err = 1'b0;
        checkOutput("busErrBusy", {31'h0, bus.busy}, 32'h0);
        checkOutput("busErrPtr", {28'h0, bus.ptr_o}, 32'h5);

        // Reset lands just before a wr_rdy would be issued.
        addrDone(1'b1);
        bus.i2c_byte_wait = 1'b1;
        #2;
        rst = 1'b1;
        tick(1);
        checkOutput("rstMidWrRdy", {31'h0, bus.i2c_wr_rdy}, 32'h0);
        checkOutput("rstMidWrData", {24'h0, bus.i2c_wr_data}, 32'h0);
        checkOutput("rstMidPtr", {28'h0, bus.ptr_o}, 32'h0);
        checkOutput("rstMidBusy", {31'h0, bus.busy}, 32'h0);
        checkOutput("rstMidStrobe", {20'h0, bus.reg_wr_addr, bus.reg_wr_data}, 32'h0);
        bus.i2c_byte_wait = 1'b0;
        bus.i2c_trans_dir = 1'b0;
        rst = 1'b0;
        hostRead("rstReg3", 4'd3, 8'h00);
        hostRead("rstReg7", 4'd7, 8'h00);

        checkOutput("wrQueueEmpty", expWr.size(), 32'd0);
        checkOutput("strobeQueueEmpty", expStrobe.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
